// File: rtl/nios2_debug_ocimem_arbiter_if.sv
// Bus bundle between the debug-slave sysclk stage / CPU debug-memory port and the
// on-chip debug RAM arbiter.
interface nios2_debug_ocimem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    // JTAG side (from the debug-slave sysclk decoder)
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    // CPU debug-memory slave port
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [3:0]        byteenable;
    logic              debugaccess;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;
    // Monitor results back to the TCK chain
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic              jtag_busy;

    modport master (
        output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        output address, read, write, writedata, byteenable, debugaccess,
        input  readdata, waitrequest, MonDReg, monitor_ready, monitor_error, jtag_busy
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
        input  address, read, write, writedata, byteenable, debugaccess,
        output readdata, waitrequest, MonDReg, monitor_ready, monitor_error, jtag_busy
    );
endinterface

// File: rtl/nios2_debug_ocimem_arbiter.sv
// Debug RAM arbiter: shares a small on-chip debug RAM between JTAG monitor accesses
// (one-entry pending slot, auto-incrementing address) and the CPU debug-memory port.
// The top word of the address space is the monitor control/status word, not RAM.
module nios2_debug_ocimem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input logic                        clk,
    input logic                        reset,
    nios2_debug_ocimem_arbiter_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CtrlAddr = '1;

    typedef enum logic [2:0] {
        StIdle,
        StCpuRd,
        StCpuWait,
        StJRd,
        StJRdWait,
        StJWr
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] mon_a_q;
    logic              slot_full_q;
    logic              slot_wr_q;
    logic [DATA_W-1:0] slot_data_q;
    logic [DATA_W-1:0] mon_d_q;
    logic [DATA_W-1:0] readdata_q;
    logic              ready_q;
    logic              error_q;
    logic              ctrl_hit_q;
    // Holds waitrequest high for the first cycle after reset falls
    logic              reset_hold_q;

    logic [DATA_W-1:0] mem [Depth];
    logic [DATA_W-1:0] mem_rdata_q;

    logic              jtag_go;
    logic              cpu_rd_go;
    logic              cpu_wr_go;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] rd_sel;
    logic              wait_c;
    logic              ctrl_wr;
    logic              clr_flags;

    logic              unused_jdo;
    assign unused_jdo = ^{bus.jdo[37], bus.jdo[1:0]};

    // Pending JTAG work always wins over a CPU request presented in the same cycle
    assign jtag_go   = (state_q == StIdle) && slot_full_q;
    assign cpu_rd_go = (state_q == StIdle) && !slot_full_q && !reset_hold_q && bus.read;
    assign cpu_wr_go = (state_q == StIdle) && !slot_full_q && !reset_hold_q && !bus.read &&
                       bus.write;
    assign rd_en     = (jtag_go && !slot_wr_q) || cpu_rd_go;
    assign rd_addr   = slot_full_q ? mon_a_q : bus.address;

    assign ctrl_wr   = cpu_wr_go && bus.debugaccess && (bus.address == CtrlAddr);
    assign clr_flags = bus.take_action_ocimem_a && bus.jdo[36] && !slot_full_q;

    // Read data source: control word when the issued address was all-ones, else RAM
    assign rd_sel = ctrl_hit_q ? {{(DATA_W-2){1'b0}}, error_q, ready_q} : mem_rdata_q;

    // RAM write port select: JTAG write state or a same-cycle CPU write
    always_comb begin
        mem_we = 1'b0;
        mem_wa = mon_a_q;
        mem_wd = slot_data_q;
        mem_be = 4'hF;
        if (state_q == StJWr) begin
            mem_we = (mon_a_q != CtrlAddr);
        end else if (cpu_wr_go) begin
            mem_we = bus.debugaccess && (bus.address != CtrlAddr);
            mem_wa = bus.address;
            mem_wd = bus.writedata;
            mem_be = bus.byteenable;
        end
    end

    // Debug RAM: byte-lane writes and a synchronous read captured only on issue
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && mem_be[b]) begin
                mem[mem_wa][8*b +: 8] <= mem_wd[8*b +: 8];
            end
        end
        if (rd_en) begin
            mem_rdata_q <= mem[rd_addr];
        end
    end

    // CPU stall decode from the registered state
    always_comb begin
        wait_c = 1'b1;
        unique case (state_q)
            StIdle:    wait_c = reset_hold_q || slot_full_q || bus.read;
            StCpuWait: wait_c = 1'b0;
            default:   wait_c = 1'b1;
        endcase
    end

    // Arbiter FSM, JTAG pending slot, monitor address/data and status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            mon_a_q      <= '0;
            slot_full_q  <= 1'b0;
            slot_wr_q    <= 1'b0;
            slot_data_q  <= '0;
            mon_d_q      <= '0;
            readdata_q   <= '0;
            ready_q      <= 1'b0;
            error_q      <= 1'b0;
            ctrl_hit_q   <= 1'b0;
            reset_hold_q <= 1'b1;
        end else begin
            reset_hold_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (jtag_go) begin
                        state_q    <= slot_wr_q ? StJWr : StJRd;
                        ctrl_hit_q <= (mon_a_q == CtrlAddr);
                    end else if (cpu_rd_go) begin
                        state_q    <= StCpuRd;
                        ctrl_hit_q <= (bus.address == CtrlAddr);
                    end
                end
                StCpuRd: begin
                    state_q    <= StCpuWait;
                    readdata_q <= rd_sel;
                end
                StCpuWait: state_q <= StIdle;
                StJRd:     state_q <= StJRdWait;
                StJRdWait: begin
                    state_q     <= StIdle;
                    mon_d_q     <= rd_sel;
                    mon_a_q     <= mon_a_q + 1'b1;
                    slot_full_q <= 1'b0;
                end
                StJWr: begin
                    state_q     <= StIdle;
                    mon_a_q     <= mon_a_q + 1'b1;
                    slot_full_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase

            // Strobes arriving while the slot is occupied are dropped entirely
            if (!slot_full_q) begin
                if (bus.take_action_ocimem_a) begin
                    mon_a_q <= bus.jdo[ADDR_W+1:2];
                    if (bus.jdo[35]) begin
                        slot_full_q <= 1'b1;
                        slot_wr_q   <= 1'b0;
                    end
                end else if (bus.take_action_ocimem_b) begin
                    slot_full_q <= 1'b1;
                    slot_wr_q   <= 1'b1;
                    slot_data_q <= bus.jdo[34:3];
                end else if (bus.take_no_action_ocimem_a) begin
                    slot_full_q <= 1'b1;
                    slot_wr_q   <= 1'b0;
                end
            end

            // Set-only flags from the CPU; a same-cycle JTAG clear overrides them
            if (ctrl_wr && bus.byteenable[0]) begin
                if (bus.writedata[0]) ready_q <= 1'b1;
                if (bus.writedata[1]) error_q <= 1'b1;
            end
            if (clr_flags) begin
                ready_q <= 1'b0;
                error_q <= 1'b0;
            end
        end
    end

    assign bus.readdata      = readdata_q;
    assign bus.waitrequest   = wait_c;
    assign bus.MonDReg       = mon_d_q;
    assign bus.monitor_ready = ready_q;
    assign bus.monitor_error = error_q;
    assign bus.jtag_busy     = slot_full_q || (state_q inside {StJRd, StJRdWait, StJWr});

endmodule
